hex_display_ctrl: RTL
=====================

Name: hex_display_ctrl

Overview:
Parametrised, sequential successor to the combinational switch-to-hex driver. It accepts a WIDTH-bit value through a valid/ready handshake and renders it on NUM_DIGITS active-low seven-segment displays in either hex or decimal. Decimal rendering uses a multi-cycle double-dabble conversion. Adds leading-zero blanking, overflow indication and a blink mode. Sits between switch/counter logic and the board HEX pins.

Parameters:
WIDTH, 10, bit width of in_value (1..32)
NUM_DIGITS, 6, number of seven-segment digits driven (1..8)
BLINK_DIV, 25000000, clock cycles per blink half-period (>=2)

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  request to display in_value
in_ready  output  1  block can accept a new value
in_value  input  WIDTH  value to display
in_mode  input  1  0 = hex, 1 = unsigned decimal
in_blank_lz  input  1  1 = blank leading zeros
blink_en  input  1  1 = blink the whole display
busy  output  1  conversion in progress (equals ~in_ready)
overflow  output  1  last accepted value does not fit in NUM_DIGITS
hex_out  output  8*NUM_DIGITS  segment patterns; digit 0 (least significant) in [7:0]

Behaviour:
- Clocking and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: state IDLE, in_ready=1, busy=0, overflow=0, display register all 8'hFF (blank), blink counter=0, blink phase=0.
- Segment encoding: active-low; bits 0..6 = segments a..g; bit 7 = DP, always 1.
  - 0..9: C0 F9 A4 B0 99 92 82 F8 80 90
  - A..F: 88 83 C6 A1 86 8E
  - Dash: BF. Blank: FF.
- Handshake: a transfer occurs on a rising edge with in_valid && in_ready. At that edge the block captures in_value, in_mode and in_blank_lz. in_valid while busy is ignored; nothing is queued.
- State machine: IDLE, SHIFT, ENCODE.
  - IDLE: hex accept -> ENCODE; decimal accept -> SHIFT with BCD register cleared and bit counter=WIDTH-1.
  - SHIFT: one double-dabble step per cycle, MSB first. Before each shift, every BCD nibble >=5 gets +3. Exactly WIDTH cycles, then -> ENCODE.
  - ENCODE: one cycle. The display register and overflow are written on the exit edge; the state returns to IDLE on the same edge.
- Latency: from the accept edge k to hex_out update is edge k+1 in hex mode and edge k+WIDTH+1 in decimal mode. in_ready rises on the update edge.
- Hex digits: nibble i of the zero-extended value.
- Overflow:
  - Hex mode: any bit at index >= 4*NUM_DIGITS is set.
  - Decimal mode: value > 10^NUM_DIGITS - 1. The comparison is against a constant at capture; the BCD register has enough nibbles for WIDTH bits.
  - On overflow, every digit shows dash (BF) and overflow=1. Otherwise overflow=0.
- Leading-zero blanking (in_blank_lz=1, no overflow): digits above the most significant nonzero digit show FF. Digit 0 is always shown, so value 0 shows C0 on digit 0.
- Blink:
  - Counter runs continuously. It wraps at BLINK_DIV-1; phase toggles on each wrap.
  - hex_out = (blink_en && phase) ? all FF : display register. This is a combinational mask of two registers.
  - The display register is unaffected by blinking.
- Reset mid-SHIFT/ENCODE: immediate return to IDLE with a blank display. No partial result is ever shown.
- Display holds its last value indefinitely while in IDLE.

Decomposition:
- Package hex_display_pkg: segment constants (SEG_0..SEG_F, SEG_DASH, SEG_BLANK), state enum (IDLE/SHIFT/ENCODE), function seg_encode(nibble).
- One sub-module: bcd_double_dabble (start, WIDTH-bit value in, BCD out, done). The top keeps the FSM, blanking, overflow and blink.

Test Plan:
1. Reset, with rst asserted mid-idle -> hex_out all FF, in_ready=1, overflow=0.
2. Hex mode, in_value=10'h3A5, blank_lz=1 -> after 1 cycle, digits 0..2 = 92, 88, B0 and digits 3..5 = FF. Repeat with blank_lz=0 -> digits 3..5 = C0.
3. Decimal mode, in_value=999 -> in_ready low for 11 cycles, then digits 0..2 = 90 90 90 and digits 3..5 = FF. A value of 0 with blank_lz=1 -> digit 0 = C0, the rest FF.
4. NUM_DIGITS=2: decimal 100 -> both digits BF, overflow=1. Then decimal 42 -> 99, A4 and overflow=0.
5. BLINK_DIV=4, blink_en=1 -> hex_out alternates between the pattern and all-FF every 4 cycles. Dropping blink_en restores the pattern immediately.
6. Assert rst 3 cycles into a decimal SHIFT -> blank display, IDLE. in_valid pulses while busy are ignored, and the displayed result matches the first accepted value.

Source files
------------

// File: rtl/hex_display_pkg.sv
// hex_display_pkg
// Shared definitions for the hex/decimal seven-segment display controller:
//   - active-low segment patterns (bit 0..6 = a..g, bit 7 = DP, DP always off)
//   - controller state encoding
//   - seg_encode():  4-bit digit -> segment pattern
//   - bcd_digits():  decimal digits needed to hold any unsigned value of a given width
//   - pow10():       10^n as a 64-bit constant, for overflow limits
package hex_display_pkg;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_A     = 8'h88;
    localparam logic [7:0] SEG_B     = 8'h83;
    localparam logic [7:0] SEG_C     = 8'hC6;
    localparam logic [7:0] SEG_D     = 8'hA1;
    localparam logic [7:0] SEG_E     = 8'h86;
    localparam logic [7:0] SEG_F     = 8'h8E;
    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        ENCODE = 2'd2
    } state_t;

    function automatic logic [7:0] seg_encode(input logic [3:0] nibble);
        logic [7:0] seg;
        case (nibble)
            4'h0:    seg = SEG_0;
            4'h1:    seg = SEG_1;
            4'h2:    seg = SEG_2;
            4'h3:    seg = SEG_3;
            4'h4:    seg = SEG_4;
            4'h5:    seg = SEG_5;
            4'h6:    seg = SEG_6;
            4'h7:    seg = SEG_7;
            4'h8:    seg = SEG_8;
            4'h9:    seg = SEG_9;
            4'hA:    seg = SEG_A;
            4'hB:    seg = SEG_B;
            4'hC:    seg = SEG_C;
            4'hD:    seg = SEG_D;
            4'hE:    seg = SEG_E;
            4'hF:    seg = SEG_F;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    // Number of decimal digits in (2^width - 1); sizes the BCD register.
    function automatic int bcd_digits(input int width);
        longint unsigned m;
        int              n;
        m = (64'd1 << width) - 64'd1;
        n = 1;
        for (int i = 0; i < 20; i++) begin
            if (m >= 64'd10) begin
                m = m / 64'd10;
                n = n + 1;
            end
        end
        return n;
    endfunction

    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

endpackage

// File: rtl/hex_display_ctrl_bcd_double_dabble.sv
// bcd_double_dabble
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per cycle, MSB first.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   i_start    load i_value and begin a conversion (ignored values are not queued)
//   i_value    WIDTH-bit unsigned input
//   o_bcd      NB BCD nibbles, least significant digit in [3:0]; held after completion
//   o_done     high during the cycle whose closing edge performs the final shift
module bcd_double_dabble
    import hex_display_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int NB    = bcd_digits(WIDTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [WIDTH-1:0]  i_value,
    output logic [4*NB-1:0]   o_bcd,
    output logic              o_done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] r_shift;
    logic [4*NB-1:0]  r_bcd;
    logic [CW-1:0]    r_cnt;
    logic             r_active;
    logic [4*NB-1:0]  w_adj;

    // Add 3 to every nibble that is 5 or more before the next shift.
    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < NB; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end else begin
                w_adj[4*i +: 4] = r_bcd[4*i +: 4];
            end
        end
    end

    // Conversion registers: load on start, then shift one binary bit into the BCD field per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift  <= {WIDTH{1'b0}};
            r_bcd    <= {(4*NB){1'b0}};
            r_cnt    <= {CW{1'b0}};
            r_active <= 1'b0;
        end else if (i_start) begin
            r_shift  <= i_value;
            r_bcd    <= {(4*NB){1'b0}};
            r_cnt    <= CW'(WIDTH - 1);
            r_active <= 1'b1;
        end else if (r_active) begin
            r_bcd   <= {w_adj[4*NB-2:0], r_shift[WIDTH-1]};
            r_shift <= r_shift << 1;
            if (r_cnt == {CW{1'b0}}) begin
                r_active <= 1'b0;
            end else begin
                r_cnt <= r_cnt - CW'(1);
            end
        end
    end

    assign o_bcd  = r_bcd;
    assign o_done = r_active && (r_cnt == {CW{1'b0}});

endmodule

// File: rtl/hex_display_ctrl.sv
// hex_display_ctrl
// Accepts a WIDTH-bit value over valid/ready and shows it on NUM_DIGITS active-low
// seven-segment digits in hex or unsigned decimal, with leading-zero blanking,
// overflow dashes and an optional whole-display blink.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   in_valid     request to display in_value
//   in_ready     block can accept a new value (only in IDLE)
//   in_value     value to display
//   in_mode      0 = hex, 1 = unsigned decimal
//   in_blank_lz  1 = blank leading zeros (digit 0 always shown)
//   blink_en     1 = blank the whole display on alternate blink half-periods
//   busy         conversion in progress (~in_ready)
//   overflow     last accepted value did not fit in NUM_DIGITS digits
//   hex_out      segment patterns, digit 0 in [7:0]
module hex_display_ctrl
    import hex_display_pkg::*;
#(
    parameter int WIDTH      = 10,
    parameter int NUM_DIGITS = 6,
    parameter int BLINK_DIV  = 25000000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in_value,
    input  logic                    in_mode,
    input  logic                    in_blank_lz,
    input  logic                    blink_en,
    output logic                    busy,
    output logic                    overflow,
    output logic [8*NUM_DIGITS-1:0] hex_out
);

    localparam int              NB        = bcd_digits(WIDTH);
    localparam int              BW        = $clog2(BLINK_DIV);
    localparam int              WPAD      = ((WIDTH + 3) / 4) * 4;
    localparam int              HEX_SHIFT = 4 * NUM_DIGITS;
    localparam longint unsigned MAX_DEC   = pow10(NUM_DIGITS) - 64'd1;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [WIDTH-1:0]        r_value;
    logic                    r_mode;
    logic                    r_blank_lz;
    logic                    r_ovf_pend;
    logic                    r_in_ready;
    logic                    r_overflow;
    logic [8*NUM_DIGITS-1:0] r_disp;
    logic [BW-1:0]           r_blink_cnt;
    logic                    r_blink_phase;

    logic                    w_accept;
    logic                    w_dd_start;
    logic                    w_dd_done;
    logic [4*NB-1:0]         w_bcd;
    logic [63:0]             w_val64;
    logic                    w_ovf_in;
    logic [WPAD-1:0]         w_val_pad;
    logic [3:0]              w_hex_digit [NUM_DIGITS];
    logic [3:0]              w_dec_digit [NUM_DIGITS];
    logic [8*NUM_DIGITS-1:0] w_disp_next;

    assign w_accept   = in_valid && r_in_ready;
    assign w_dd_start = w_accept && in_mode;
    assign w_val64    = 64'(in_value);
    assign w_val_pad  = WPAD'(r_value);

    // Overflow is decided against a constant limit at capture time, independent of the converter.
    assign w_ovf_in = in_mode ? (w_val64 > MAX_DEC)
                              : ((w_val64 >> HEX_SHIFT) != 64'd0);

    bcd_double_dabble #(
        .WIDTH (WIDTH),
        .NB    (NB)
    ) u_dd (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_dd_start),
        .i_value (in_value),
        .o_bcd   (w_bcd),
        .o_done  (w_dd_done)
    );

    // Digits beyond the source width read as zero.
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
        if (g < NB) begin : g_dec
            assign w_dec_digit[g] = w_bcd[4*g +: 4];
        end else begin : g_dec_zero
            assign w_dec_digit[g] = 4'd0;
        end
        if (4*g < WIDTH) begin : g_hex
            assign w_hex_digit[g] = w_val_pad[4*g +: 4];
        end else begin : g_hex_zero
            assign w_hex_digit[g] = 4'd0;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = in_mode ? SHIFT : ENCODE;
                end else begin
                    w_state_next = IDLE;
                end
            end
            SHIFT: begin
                if (w_dd_done) begin
                    w_state_next = ENCODE;
                end else begin
                    w_state_next = SHIFT;
                end
            end
            ENCODE:  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Segment image for the captured value: dashes on overflow, else digits with optional
    // blanking of zeros above the most significant nonzero digit (scanned top-down).
    always_comb begin
        logic w_lz;
        logic [3:0] w_d;
        w_disp_next = {NUM_DIGITS{SEG_BLANK}};
        w_lz        = 1'b1;
        w_d         = 4'd0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_d = r_mode ? w_dec_digit[i] : w_hex_digit[i];
            if (r_ovf_pend) begin
                w_disp_next[8*i +: 8] = SEG_DASH;
            end else if (r_blank_lz && w_lz && (w_d == 4'd0) && (i != 0)) begin
                w_disp_next[8*i +: 8] = SEG_BLANK;
            end else begin
                w_disp_next[8*i +: 8] = seg_encode(w_d);
            end
            w_lz = w_lz && (w_d == 4'd0);
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Capture request fields, track readiness, and publish the result on the ENCODE exit edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_value    <= {WIDTH{1'b0}};
            r_mode     <= 1'b0;
            r_blank_lz <= 1'b0;
            r_ovf_pend <= 1'b0;
            r_in_ready <= 1'b1;
            r_overflow <= 1'b0;
            r_disp     <= {NUM_DIGITS{SEG_BLANK}};
        end else if (w_accept) begin
            r_value    <= in_value;
            r_mode     <= in_mode;
            r_blank_lz <= in_blank_lz;
            r_ovf_pend <= w_ovf_in;
            r_in_ready <= 1'b0;
        end else if (r_state == ENCODE) begin
            r_disp     <= w_disp_next;
            r_overflow <= r_ovf_pend;
            r_in_ready <= 1'b1;
        end
    end

    // Free-running blink divider; phase flips on every wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blink_cnt   <= {BW{1'b0}};
            r_blink_phase <= 1'b0;
        end else if (r_blink_cnt == BW'(BLINK_DIV - 1)) begin
            r_blink_cnt   <= {BW{1'b0}};
            r_blink_phase <= ~r_blink_phase;
        end else begin
            r_blink_cnt   <= r_blink_cnt + BW'(1);
        end
    end

    assign in_ready = r_in_ready;
    assign busy     = ~r_in_ready;
    assign overflow = r_overflow;
    assign hex_out  = (blink_en && r_blink_phase) ? {NUM_DIGITS{SEG_BLANK}} : r_disp;

endmodule
